bin2bcd_seq_ctrl: RTL and testbench

Sequential binary-to-BCD converter controller using shift-and-add-3 (double dabble), one bit per clock.
- Accepts an unsigned BIN_W-bit value over a valid/ready handshake.
- Runs the digit-correct and shift datapath for BIN_W cycles.
- Presents DIGITS packed BCD digits over a valid/ready output handshake.
- Sits between the binary arithmetic units and the 7-segment digit decoders; replaces per-width combinational correction logic.

---
 rtl/bin2bcd_pkg.sv | 22 ++
 rtl/bcd_digit_adjust.sv | 11 +
 rtl/bin2bcd_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_bin2bcd_seq_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared FSM encodings, digit-adjust constants and helpers for bin2bcd
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// rtl/bcd_digit_adjust.sv - double-dabble digit correction: add 3 to a BCD digit that is 5 or more
module bcd_digit_adjust
    import bin2bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= BCD_ADJ_THRESH) ? din + BCD_ADJ_ADD : din;

endmodule

// File: rtl/bin2bcd_seq_ctrl.sv
// rtl/bin2bcd_seq_ctrl.sv - sequential binary-to-BCD converter, one bit per clock
// Optional two's-complement input with sign_out when BIN2BCD_SIGNED_EN is defined.
module bin2bcd_seq_ctrl
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
`ifdef BIN2BCD_SIGNED_EN
    output logic                  sign_out,
`endif
    output logic                  busy
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int CAT_W = 4 * DIGITS + BIN_W;
`ifdef BIN2BCD_SIGNED_EN
    localparam longint unsigned MAX_MAG = 64'd1 << (BIN_W - 1);
`else
    localparam longint unsigned MAX_MAG = (64'd1 << BIN_W) - 64'd1;
`endif

    generate
        if (pow10(DIGITS) <= MAX_MAG) begin : g_digits_too_few
            $error("bin2bcd_seq_ctrl: DIGITS too small for BIN_W");
        end
    endgenerate

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [BIN_W-1:0]      bin_sh;
    logic [4*DIGITS-1:0]   bcd_work;
    logic [4*DIGITS-1:0]   bcd_adj;
    logic [CAT_W-1:0]      cat_shifted;
    logic [BIN_W-1:0]      load_val;
    logic                  last_shift;

    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_adj
            bcd_digit_adjust u_adj (
                .din  (bcd_work[4*k +: 4]),
                .dout (bcd_adj[4*k +: 4])
            );
        end
    endgenerate

    // Correct first, then shift the concatenated {bcd, bin} register left by one.
    assign cat_shifted = {bcd_adj, bin_sh} << 1;
    assign last_shift  = (cnt == CNT_W'(BIN_W - 1));

`ifdef BIN2BCD_SIGNED_EN
    // -2^(BIN_W-1) negates to itself, which reads correctly as an unsigned magnitude.
    assign load_val = bin_in[BIN_W-1] ? (BIN_W'(0) - bin_in) : bin_in;
`else
    assign load_val = bin_in;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (in_valid)   state_nxt = ST_SHIFT;
            ST_SHIFT: if (last_shift) state_nxt = ST_DONE;
            ST_DONE:  if (out_ready)  state_nxt = ST_IDLE;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
        busy      = (state == ST_SHIFT) || (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            bin_sh   <= '0;
            bcd_work <= '0;
            bcd_out  <= '0;
`ifdef BIN2BCD_SIGNED_EN
            sign_out <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        bin_sh   <= load_val;
                        bcd_work <= '0;
                        cnt      <= '0;
`ifdef BIN2BCD_SIGNED_EN
                        sign_out <= bin_in[BIN_W-1];
`endif
                    end
                end
                ST_SHIFT: begin
                    bcd_work <= cat_shifted[CAT_W-1:BIN_W];
                    bin_sh   <= cat_shifted[BIN_W-1:0];
                    cnt      <= cnt + CNT_W'(1);
                    if (last_shift) begin
                        bcd_out <= cat_shifted[CAT_W-1:BIN_W];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq_ctrl.sv
// tb/tb_bin2bcd_seq_ctrl.sv - self-checking bench for bin2bcd_seq_ctrl (BIN2BCD_SIGNED_EN aware)
module tb_bin2bcd_seq_ctrl;

    localparam int BIN_W  = 8;
    localparam int DIGITS = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  bin_in;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] bcd_out;
    logic        busy;
`ifdef BIN2BCD_SIGNED_EN
    logic        sign_out;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin2bcd_seq_ctrl #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_in    (bin_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd_out   (bcd_out),
`ifdef BIN2BCD_SIGNED_EN
        .sign_out  (sign_out),
`endif
        .busy      (busy)
    );

    function automatic logic [11:0] ref_bcd(input logic [7:0] v);
        int m;
        m = int'(v);
`ifdef BIN2BCD_SIGNED_EN
        if (v[7]) m = 256 - int'(v);
`endif
        return {4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_conv(input logic [7:0] v, input logic keep_valid, output int acc_cyc);
        int n;
        int lat;
        logic [11:0] exp;
        exp = ref_bcd(v);
        in_valid = 1'b1;
        bin_in   = v;
        n = 0;
        while (!in_ready && n < 50) begin
            tick;
            n++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        tick;
        acc_cyc = cyc;
        if (!keep_valid) in_valid = 1'b0;
        bin_in = 8'($urandom);
        check("busy_shift", 32'(busy), 32'd1);
        check("ready_shift", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick;
            lat++;
        end
        check("latency", 32'(lat), 32'(BIN_W));
        check("bcd_value", 32'(bcd_out), 32'(exp));
`ifdef BIN2BCD_SIGNED_EN
        check("sign_value", 32'(sign_out), 32'(v[7]));
`endif
        if (out_ready) begin
            tick;
            check("valid_one_cycle", 32'(out_valid), 32'd0);
            check("ready_after_done", 32'(in_ready), 32'd1);
            check("bcd_retained", 32'(bcd_out), 32'(exp));
        end
    endtask

    initial begin
        int acc;
        int prev;
        logic [7:0] v;
        logic [7:0] directed [9];
        directed = '{8'd255, 8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'h80, 8'hFF, 8'h7F};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; bin_in = 8'd0;
        tick;
        tick;
        check("rst_bcd", 32'(bcd_out), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        tick;
        check("post_rst_ready", 32'(in_ready), 32'd1);

        foreach (directed[i]) do_conv(directed[i], 1'b0, acc);

        out_ready = 1'b0;
        do_conv(8'd128, 1'b0, acc);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            bin_in   = 8'd7;
            tick;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_ready", 32'(in_ready), 32'd0);
            check("bp_hold", 32'(bcd_out), 32'(ref_bcd(8'd128)));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        check("bp_retained", 32'(bcd_out), 32'(ref_bcd(8'd128)));
        do_conv(8'd7, 1'b0, acc);

        in_valid = 1'b1;
        bin_in   = 8'd200;
        tick;
        in_valid = 1'b0;
        check("abort_busy", 32'(busy), 32'd1);
        tick;
        tick;
        tick;
        rst_n = 1'b0;
        tick;
        check("abort_bcd", 32'(bcd_out), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        do_conv(8'd37, 1'b0, acc);

        prev = 0;
        for (int i = 0; i < 16; i++) begin
            v = 8'($urandom);
            do_conv(v, 1'b1, acc);
            if (i > 0) check("b2b_interval", 32'(acc - prev), 32'(BIN_W + 2));
            prev = acc;
        end
        in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
